// File: rtl/uart_pkg.sv
// Shared UART definitions used by the wide transmitter and the matching receiver.
package uart_pkg;

   localparam int unsigned OS_TICKS  = 16;
   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_wide_if.sv
// Request/status bundle between the wide-word producer and uart_tx_wide.
interface uart_tx_wide_if #(
   parameter int unsigned DBIT = 160
);
   logic            tx_start;
   logic [DBIT-1:0] tx_din;
   logic            tx_busy;
   logic            tx_done_tick;

   modport master (output tx_start, tx_din, input  tx_busy, tx_done_tick);
   modport slave  (input  tx_start, tx_din, output tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte UART framer (start, 8 data LSB first, optional parity, stop) on 16x s_tick.
// `define UART_TX_PARITY_EN inserts an even-parity bit between data and stop (8E1).
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int unsigned SB_TICK = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_s_tick,
   input  logic                 i_start,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_tx,
   output logic                 o_done_c
);

   localparam int unsigned SW = cnt_w((SB_TICK > OS_TICKS) ? SB_TICK : OS_TICKS);
   localparam int unsigned NW = cnt_w(DATA_BITS);
   localparam logic [SW-1:0] BIT_LAST  = SW'(OS_TICKS - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
   localparam uart_state_e AFTER_DATA = PARITY;
`else
   localparam uart_state_e AFTER_DATA = STOP;
`endif

   uart_state_e   r_state, w_state_nxt;
   logic [SW-1:0] r_s_cnt, w_s_cnt_nxt;
   logic [NW-1:0] r_n_cnt, w_n_cnt_nxt;
   logic          r_tx, w_tx_nxt;
   logic          w_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_s_cnt <= '0;
         r_n_cnt <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_s_cnt <= w_s_cnt_nxt;
         r_n_cnt <= w_n_cnt_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // A start request at the end of STOP chains straight into the next START.
   always_comb begin
      w_state_nxt = r_state;
      w_s_cnt_nxt = r_s_cnt;
      w_n_cnt_nxt = r_n_cnt;
      w_done      = 1'b0;
      case (r_state)
         IDLE: if (i_start) begin
            w_state_nxt = START;
            w_s_cnt_nxt = '0;
            w_n_cnt_nxt = '0;
         end
         START: if (i_s_tick) begin
            if (r_s_cnt == BIT_LAST) begin
               w_s_cnt_nxt = '0;
               w_state_nxt = DATA;
            end else begin
               w_s_cnt_nxt = r_s_cnt + SW'(1);
            end
         end
         DATA: if (i_s_tick) begin
            if (r_s_cnt == BIT_LAST) begin
               w_s_cnt_nxt = '0;
               if (r_n_cnt == N_LAST) w_state_nxt = AFTER_DATA;
               else                   w_n_cnt_nxt = r_n_cnt + NW'(1);
            end else begin
               w_s_cnt_nxt = r_s_cnt + SW'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (i_s_tick) begin
            if (r_s_cnt == BIT_LAST) begin
               w_s_cnt_nxt = '0;
               w_state_nxt = STOP;
            end else begin
               w_s_cnt_nxt = r_s_cnt + SW'(1);
            end
         end
`endif
         STOP: if (i_s_tick) begin
            if (r_s_cnt == STOP_LAST) begin
               w_done      = 1'b1;
               w_s_cnt_nxt = '0;
               w_n_cnt_nxt = '0;
               w_state_nxt = i_start ? START : IDLE;
            end else begin
               w_s_cnt_nxt = r_s_cnt + SW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Line level is decoded from the next state so tx leaves a flop aligned with the state.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = i_data[w_n_cnt_nxt];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_tx_nxt = ^i_data;
`endif
         default: w_tx_nxt = 1'b1;
      endcase
   end

   assign o_tx     = r_tx;
   assign o_done_c = w_done;

endmodule

// File: rtl/uart_tx_wide.sv
// Sends a DBIT-wide word as DBIT/8 back-to-back UART frames, MSB byte first.
// Parity framing is selected by `define UART_TX_PARITY_EN inside uart_tx_byte.
module uart_tx_wide
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = 160,
   parameter int unsigned SB_TICK = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_tick,
   uart_tx_wide_if.slave  bus,
   output logic           tx
);

   localparam int unsigned NBYTES = DBIT / DATA_BITS;
   localparam int unsigned BW     = cnt_w(NBYTES);
   localparam logic [BW-1:0] B_LAST = BW'(NBYTES - 1);

   if (DBIT == 0 || (DBIT % DATA_BITS) != 0) begin : g_dbit_chk
      $error("uart_tx_wide: DBIT must be a non-zero multiple of 8");
   end

   logic [DBIT-1:0] r_buf;
   logic [BW-1:0]   r_b_cnt;
   logic            r_busy;
   logic            r_done;
   logic            w_accept;
   logic            w_last;
   logic            w_byte_done;
   logic            w_byte_start;

   // The done cycle still blocks acceptance; the following cycle may start again.
   assign w_accept     = bus.tx_start && !r_busy && !r_done;
   assign w_last       = (r_b_cnt == B_LAST);
   assign w_byte_start = w_accept || (w_byte_done && !w_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf   <= '0;
         r_b_cnt <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_buf   <= bus.tx_din;
            r_b_cnt <= '0;
            r_busy  <= 1'b1;
         end else if (w_byte_done) begin
            if (w_last) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_b_cnt <= r_b_cnt + BW'(1);
               r_buf   <= r_buf << DATA_BITS;
            end
         end
      end
   end

   uart_tx_byte #(
      .SB_TICK (SB_TICK)
   ) u_byte (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_s_tick (s_tick),
      .i_start  (w_byte_start),
      .i_data   (r_buf[DBIT-1 -: DATA_BITS]),
      .o_tx     (tx),
      .o_done_c (w_byte_done)
   );

   assign bus.tx_busy      = r_busy;
   assign bus.tx_done_tick = r_done;

endmodule
